note_judge_n: RTL

- Lane-parametrised note judgement and scoring unit for the guitar-hero processor.
- Synchronises and debounces the strum input, and takes one judgement per game-clock window.
- Compares pressed buttons against note intersections across LANES lanes.
- Maintains score, streak and a streak-based multiplier, and exposes score to the processor's score input.

---
 rtl/note_judge_n.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/note_judge_n.sv
// note_judge_n: strum/game-tick synchroniser, debouncer and note judge.
// Ports: clock/reset, gameclk/strum (async), buttons/intersections (sync),
//        score/streak/multiplier, hit_pulse/miss_pulse (registered).
module note_judge_n #(
  parameter int LANES           = 4,
  parameter int SCORE_W         = 32,
  parameter int STREAK_W        = 8,
  parameter int DEBOUNCE        = 4,
  parameter int HIT_PTS         = 1,
  parameter int STREAK_PER_MULT = 10,
  parameter int MAX_MULT        = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                gameclk,
  input  logic                strum,
  input  logic [LANES-1:0]    buttons,
  input  logic [LANES-1:0]    intersections,
  output logic [SCORE_W-1:0]  score,
  output logic [STREAK_W-1:0] streak,
  output logic [2:0]          multiplier,
  output logic                hit_pulse,
  output logic                miss_pulse
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int AW = SCORE_W + 8;

  typedef enum logic [1:0] {
    IDLE,
    JUDGE,
    COOLDOWN
  } state_t;

  // synchronisers
  logic gc_s1_q, gc_s2_q, gc_s3_q;
  logic st_s1_q, st_s2_q;

  // debouncer
  logic          db_q, db_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // judge state
  state_t             state_q, state_d;
  logic [LANES-1:0]   btn_q, btn_d;
  logic [LANES-1:0]   int_q, int_d;
  logic               note_q, note_d;
  logic               judged_q, judged_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [2:0]         mult_q, mult_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;

  logic          tick;
  logic          strum_ev;
  logic          tick_miss;
  logic          is_hit;
  logic [AW-1:0] sum_w;
  logic [31:0]   quot_w;

  assign tick = gc_s2_q & ~gc_s3_q;

  // Level flips only after DEBOUNCE consecutive disagreeing cycles;
  // the event fires on the same edge that the level rises.
  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (st_s2_q != db_q) begin
      if (cnt_q == CW'(DEBOUNCE - 1)) begin
        db_d = st_s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  assign strum_ev = db_d & ~db_q;

  assign is_hit = (btn_q == int_q) && (|int_q);

  // Saturating add uses the pre-hit multiplier.
  assign sum_w = AW'(score_q) + (AW'(HIT_PTS) * AW'(mult_q));

  assign quot_w = 32'(streak_q) / 32'(STREAK_PER_MULT);

  always_comb begin
    if (quot_w >= 32'(MAX_MULT - 1)) begin
      mult_d = 3'(MAX_MULT);
    end else begin
      mult_d = 3'(quot_w + 32'd1);
    end
  end

  // A note left unjudged when the window closes is a miss. While JUDGE
  // runs, the judgement itself stands in for the window's verdict.
  assign tick_miss = tick && note_q && !judged_q && (state_q != JUDGE);

  always_comb begin
    state_d  = state_q;
    btn_d    = btn_q;
    int_d    = int_q;
    note_d   = note_q | (|intersections);
    judged_d = judged_q;
    score_d  = score_q;
    streak_d = streak_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;

    // Close the old window before anything else this cycle.
    if (tick) begin
      note_d   = |intersections;
      judged_d = 1'b0;
      if (tick_miss) begin
        miss_d   = 1'b1;
        streak_d = '0;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (strum_ev) begin
          btn_d   = buttons;
          int_d   = intersections;
          state_d = JUDGE;
        end
      end
      JUDGE: begin
        if (is_hit) begin
          hit_d = 1'b1;
          if (streak_q != '1) begin
            streak_d = streak_q + STREAK_W'(1);
          end
          if (sum_w[AW-1:SCORE_W] != '0) begin
            score_d = '1;
          end else begin
            score_d = sum_w[SCORE_W-1:0];
          end
        end else begin
          miss_d   = 1'b1;
          streak_d = '0;
        end
        // A judgement that coincides with a tick belongs to the window
        // that just closed, so the new window starts open and unjudged.
        judged_d = ~tick;
        state_d  = tick ? IDLE : COOLDOWN;
      end
      COOLDOWN: begin
        if (tick && strum_ev) begin
          btn_d   = buttons;
          int_d   = intersections;
          state_d = JUDGE;
        end else if (tick) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gc_s1_q  <= 1'b0;
      gc_s2_q  <= 1'b0;
      gc_s3_q  <= 1'b0;
      st_s1_q  <= 1'b0;
      st_s2_q  <= 1'b0;
      db_q     <= 1'b0;
      cnt_q    <= '0;
      state_q  <= IDLE;
      btn_q    <= '0;
      int_q    <= '0;
      note_q   <= 1'b0;
      judged_q <= 1'b0;
      score_q  <= '0;
      streak_q <= '0;
      mult_q   <= 3'd1;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      gc_s1_q  <= gameclk;
      gc_s2_q  <= gc_s1_q;
      gc_s3_q  <= gc_s2_q;
      st_s1_q  <= strum;
      st_s2_q  <= st_s1_q;
      db_q     <= db_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
      btn_q    <= btn_d;
      int_q    <= int_d;
      note_q   <= note_d;
      judged_q <= judged_d;
      score_q  <= score_d;
      streak_q <= streak_d;
      mult_q   <= mult_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
    end
  end

  assign score      = score_q;
  assign streak     = streak_q;
  assign multiplier = mult_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;

endmodule
